aes_sync_key_loader: RTL and testbench
======================================

Name: aes_sync_key_loader

Overview:
Header-parsing stage directly upstream of the AES encryption state machine. Receives a header packet (128-bit sync, then 128-bit key) as a word stream on an Avalon-ST slave. Assembles both fields and presents them as one single-beat transfer on the Avalon-ST master that drives the encryptor's sync_and_key_in. Also detects malformed header packets, flags repeated syncs, and can optionally discard them.

Parameters:
DATA_W, 32, input word width; legal values 8/16/32/64/128; N = 128/DATA_W words per field.
DROP_SAME_SYNC, 0, 1 = discard a header whose sync equals the last delivered sync.
CNT_W, 16, width of the delivered-header counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
hdr_in  avalon_st_if.slave  data DATA_W  header words: valid, rdy, sop, eop, data.
sync_key_out  avalon_st_if.master  sync 128, key 128  to the encryptor: valid, rdy, sop, eop, sync, key.
same_sync  out  1  high while sync_key_out.valid and sync equals the last delivered sync.
short_err  out  1  1-cycle pulse: eop arrived before 2N words.
long_err  out  1  1-cycle pulse: word 2N-1 accepted without eop.
sop_err  out  1  1-cycle pulse: sop arrived mid-header.
orphan_err  out  1  1-cycle pulse: word accepted in IDLE without sop.
drop_same  out  1  1-cycle pulse: header discarded by DROP_SAME_SYNC.
hdr_cnt  out  CNT_W  count of delivered headers; wraps to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Word counter, sync/key registers, last_sync and last_sync_vld are cleared.
  - hdr_cnt is 0.
  - All pulses, same_sync and sync_key_out.valid/sop/eop are 0.
  - hdr_in.rdy is 0 while in reset and 1 in the first cycle after release.
- Accept condition: a word is accepted when hdr_in.valid & hdr_in.rdy.
- hdr_in.rdy is 1 in IDLE, COLLECT and DROP, and 0 in HOLD (no skid; the output is a single holding register).
- Field packing: words are MSB first.
  - Word i (0..N-1) goes to sync[127-i*DATA_W -: DATA_W].
  - Word N+i goes to key[127-i*DATA_W -: DATA_W].
  - The word counter is log2(2N)+1 bits wide and resets to 0 on every new header.
- State IDLE:
  - Accepted word with sop: store word 0, counter = 1, go to COLLECT.
  - Exception in IDLE: if the word also has eop and 2N>1, pulse short_err and stay in IDLE.
  - Accepted word without sop: pulse orphan_err, drop the word, stay in IDLE.
- State COLLECT, on an accepted word:
  - sop: pulse sop_err, restart with this word as word 0 (counter = 1). If this word also has eop, apply the short-packet rule.
  - eop with counter+1 < 2N: pulse short_err, discard, go to IDLE.
  - Final word (counter = 2N-1) with eop: store it, go to HOLD.
  - Final word without eop: pulse long_err, discard, go to DROP.
  - Otherwise: store the word, counter++.
- State DROP:
  - Accept and discard words until eop is accepted, then go to IDLE.
  - A sop seen in DROP is discarded; no sop_err is raised.
- State HOLD:
  - sync_key_out.valid = sop = eop = 1; sync and key are stable until handshake.
  - On sync_key_out.valid & rdy:
    - last_sync <= sync, last_sync_vld <= 1.
    - hdr_cnt++ (wraps from 2^CNT_W-1 to 0).
    - Go to IDLE.
  - hdr_in.rdy returns to 1 the cycle after the handshake.
- same_sync is combinational in HOLD: last_sync_vld & (sync == last_sync). It is 0 in every other state.
- DROP_SAME_SYNC=1: on entering HOLD with a sync equal to last_sync (and last_sync_vld), do not assert valid. Pulse drop_same, leave last_sync and hdr_cnt unchanged, and return to IDLE the next cycle.
- Latency: final word accepted at cycle t gives sync_key_out.valid at t+1. Minimum header period is 2N+1 cycles plus output stall cycles.
- Simultaneous events:
  - sop+eop on the same word is handled per the rules above.
  - Error pulses are mutually exclusive per cycle, with priority sop_err > short_err > long_err.
- Reset mid-packet or mid-HOLD: the partial header or pending output is lost, and last_sync_vld is cleared.
- No X propagation: sync/key registers are only written on accepted words.

Test Plan:
- DATA_W=32; 8 words, sop on 0x00112233, eop on word 7, sync=00112233_44556677_8899AABB_CCDDEEFF, key=0F0E0D0C_..._03020100, out.rdy=1 -> valid one cycle after word 7 with the exact sync/key, sop=eop=1, hdr_cnt=1, same_sync=0.
- Same header sent twice, out.rdy held 0 for 5 cycles on the second one -> hdr_in.rdy=0, fields stable and valid=1 throughout the stall, same_sync=1. With DROP_SAME_SYNC=1 -> no valid, drop_same pulse, hdr_cnt stays 1.
- Packet with eop on word 5 -> short_err pulse at word 5, no output, next correct header delivered normally.
- 10-word packet with eop on word 9 -> long_err at word 7, words 8-9 dropped, no output, back to IDLE.
- sop reasserted on word 3, followed by 8 good words -> sop_err pulse, output holds only the last 8 words.
- rst asserted during word 4 and released, then a full header -> no stale data, same_sync=0, hdr_cnt=1. Also set hdr_cnt near wrap (CNT_W=2, 5 headers) -> count reads 1.

Source files
------------

// File: rtl/aes_sync_key_loader.sv
// aes_sync_key_loader: assembles a 128-bit sync + 128-bit key header from a word stream into one output beat
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_hdr_valid/o_hdr_rdy    : header word handshake; i_hdr_sop/i_hdr_eop/i_hdr_data carry the word
//   o_sk_valid/i_sk_rdy      : output handshake; o_sk_sop/o_sk_eop/o_sk_sync/o_sk_key form the single beat
//   o_same_sync              : held output's sync equals the last delivered sync
//   o_short_err/o_long_err/o_sop_err/o_orphan_err/o_drop_same : one-cycle event pulses
//   o_hdr_cnt                : delivered header count, wrapping
module aes_sync_key_loader #(
  parameter int DATA_W = 32,
  parameter bit DROP_SAME_SYNC = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hdr_valid,
  output logic              o_hdr_rdy,
  input  logic              i_hdr_sop,
  input  logic              i_hdr_eop,
  input  logic [DATA_W-1:0] i_hdr_data,
  output logic              o_sk_valid,
  input  logic              i_sk_rdy,
  output logic              o_sk_sop,
  output logic              o_sk_eop,
  output logic [127:0]      o_sk_sync,
  output logic [127:0]      o_sk_key,
  output logic              o_same_sync,
  output logic              o_short_err,
  output logic              o_long_err,
  output logic              o_sop_err,
  output logic              o_orphan_err,
  output logic              o_drop_same,
  output logic [CNT_W-1:0]  o_hdr_cnt
);
  localparam int N = 128 / DATA_W;
  localparam int NW = 2 * N;
  localparam int CW = $clog2(NW) + 1;
  typedef enum logic [1:0] {IDLE, COLLECT, DROP, HOLD} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [255:0]     r_fld;
  logic [127:0]     r_last_sync;
  logic             r_last_vld;
  logic             r_rdy;
  logic             r_vld;
  logic             r_short_err;
  logic             r_long_err;
  logic             r_sop_err;
  logic             r_orphan_err;
  logic             r_drop_same;
  logic [CNT_W-1:0] r_hdr_cnt;
  logic             w_acc;
  logic             w_last;
  logic             w_match;
  logic [7:0]       w_pos;
  assign w_acc   = i_hdr_valid & r_rdy;
  assign w_last  = r_cnt == CW'(NW - 1);
  assign w_match = r_last_vld & (r_fld[255:128] == r_last_sync);
  // sync and key form one 256-bit register so word i always lands MSB-first at 255-i*DATA_W
  assign w_pos   = 8'(255 - DATA_W * int'(r_cnt));
  assign o_hdr_rdy    = r_rdy;
  assign o_sk_valid   = r_vld;
  assign o_sk_sop     = r_vld;
  assign o_sk_eop     = r_vld;
  assign o_sk_sync    = r_fld[255:128];
  assign o_sk_key     = r_fld[127:0];
  assign o_same_sync  = r_vld & w_match;
  assign o_short_err  = r_short_err;
  assign o_long_err   = r_long_err;
  assign o_sop_err    = r_sop_err;
  assign o_orphan_err = r_orphan_err;
  assign o_drop_same  = r_drop_same;
  assign o_hdr_cnt    = r_hdr_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_fld        <= '0;
      r_last_sync  <= '0;
      r_last_vld   <= 1'b0;
      r_rdy        <= 1'b0;
      r_vld        <= 1'b0;
      r_short_err  <= 1'b0;
      r_long_err   <= 1'b0;
      r_sop_err    <= 1'b0;
      r_orphan_err <= 1'b0;
      r_drop_same  <= 1'b0;
      r_hdr_cnt    <= '0;
    end else begin
      r_short_err  <= 1'b0;
      r_long_err   <= 1'b0;
      r_sop_err    <= 1'b0;
      r_orphan_err <= 1'b0;
      r_drop_same  <= 1'b0;
      r_rdy        <= 1'b1;
      case (r_state)
        IDLE: if (w_acc) begin
          if (!i_hdr_sop) r_orphan_err <= 1'b1;
          else if (i_hdr_eop) r_short_err <= 1'b1;
          else begin
            r_fld[255 -: DATA_W] <= i_hdr_data;
            r_cnt <= CW'(1);
            r_state <= COLLECT;
          end
        end
        COLLECT: if (w_acc) begin
          if (i_hdr_sop) begin
            r_sop_err <= 1'b1;
            r_fld[255 -: DATA_W] <= i_hdr_data;
            r_cnt <= CW'(1);
            if (i_hdr_eop) r_state <= IDLE;
          end else if (i_hdr_eop && !w_last) begin
            r_short_err <= 1'b1;
            r_state <= IDLE;
          end else if (!i_hdr_eop && w_last) begin
            r_long_err <= 1'b1;
            r_state <= DROP;
          end else begin
            r_fld[w_pos -: DATA_W] <= i_hdr_data;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              // the final word is always a key word, so the sync is complete for the repeat test
              r_state <= HOLD;
              r_rdy <= 1'b0;
              r_vld <= !(DROP_SAME_SYNC && w_match);
              r_drop_same <= DROP_SAME_SYNC && w_match;
            end
          end
        end
        DROP: if (w_acc && i_hdr_eop) r_state <= IDLE;
        HOLD: begin
          r_cnt <= '0;
          if (!r_vld) r_state <= IDLE;
          else if (i_sk_rdy) begin
            r_last_sync <= r_fld[255:128];
            r_last_vld <= 1'b1;
            r_hdr_cnt <= r_hdr_cnt + CNT_W'(1);
            r_vld <= 1'b0;
            r_state <= IDLE;
          end else r_rdy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_sync_key_loader.sv
// tb_aes_sync_key_loader: directed stimulus on two loader instances checked against a packet-level model
module tb_aes_sync_key_loader;
  localparam logic [255:0] H1 = {128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h0F0E0D0C_0B0A0908_07060504_03020100};
  localparam logic [255:0] H2 = {128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 128'h11111111_22222222_33333333_44444444};
  localparam logic [255:0] H3 = {128'hCAFEF00D_55AA55AA_0BADC0DE_76543210, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, out_rdy = 1'b1;
  logic [31:0] in_data = '0;
  logic rdy_a, vld_a, sop_a, eop_a, same_a, short_a, long_a, soperr_a, orph_a, drop_a;
  logic rdy_b, vld_b, sop_b, eop_b, same_b, short_b, long_b, soperr_b, orph_b, drop_b;
  logic [127:0] sync_a, key_a, sync_b, key_b;
  logic [15:0] cnt_a;
  logic [1:0] cnt_b;
  int checks = 0, failures = 0;
  int n_long = 0, n_sop = 0;
  bit m_run;
  bit m_hold[2], m_vld[2], m_lastv[2], m_drop[2];
  bit p_short[2], p_long[2], p_sop[2], p_orph[2], p_drop[2];
  int mn[2], m_cnt[2];
  logic [31:0] mw[2][8];
  logic [127:0] m_sync[2], m_key[2], m_last[2];
  always #5 clk = ~clk;
  aes_sync_key_loader #(.DATA_W(32), .DROP_SAME_SYNC(1'b0), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdr_valid(in_valid), .o_hdr_rdy(rdy_a), .i_hdr_sop(in_sop),
    .i_hdr_eop(in_eop), .i_hdr_data(in_data), .o_sk_valid(vld_a), .i_sk_rdy(out_rdy), .o_sk_sop(sop_a),
    .o_sk_eop(eop_a), .o_sk_sync(sync_a), .o_sk_key(key_a), .o_same_sync(same_a), .o_short_err(short_a),
    .o_long_err(long_a), .o_sop_err(soperr_a), .o_orphan_err(orph_a), .o_drop_same(drop_a), .o_hdr_cnt(cnt_a));
  aes_sync_key_loader #(.DATA_W(32), .DROP_SAME_SYNC(1'b1), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdr_valid(in_valid), .o_hdr_rdy(rdy_b), .i_hdr_sop(in_sop),
    .i_hdr_eop(in_eop), .i_hdr_data(in_data), .o_sk_valid(vld_b), .i_sk_rdy(out_rdy), .o_sk_sop(sop_b),
    .o_sk_eop(eop_b), .o_sk_sync(sync_b), .o_sk_key(key_b), .o_same_sync(same_b), .o_short_err(short_b),
    .o_long_err(long_b), .o_sop_err(soperr_b), .o_orphan_err(orph_b), .o_drop_same(drop_b), .o_hdr_cnt(cnt_b));
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  task automatic m_reset();
    m_run = 0;
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_vld[k] = 0; m_lastv[k] = 0; m_drop[k] = 0; mn[k] = 0; m_cnt[k] = 0;
      m_sync[k] = '0; m_key[k] = '0; m_last[k] = '0;
      p_short[k] = 0; p_long[k] = 0; p_sop[k] = 0; p_orph[k] = 0; p_drop[k] = 0;
    end
  endtask
  // instance 1 discards repeated syncs and counts modulo 4
  task automatic step(input int k);
    logic [127:0] s;
    bit match;
    p_short[k] = 0; p_long[k] = 0; p_sop[k] = 0; p_orph[k] = 0; p_drop[k] = 0;
    if (!m_run) return;
    if (m_hold[k]) begin
      if (!m_vld[k]) m_hold[k] = 0;
      else if (out_rdy) begin
        m_last[k] = m_sync[k]; m_lastv[k] = 1; m_cnt[k] = (m_cnt[k] + 1) % (k == 1 ? 4 : 65536);
        m_hold[k] = 0; m_vld[k] = 0;
      end
    end else if (in_valid) begin
      if (m_drop[k]) m_drop[k] = !in_eop;
      else if (in_sop) begin
        if (mn[k] > 0) p_sop[k] = 1;
        else if (in_eop) p_short[k] = 1;
        mn[k] = 0;
        if (!in_eop) begin mw[k][0] = in_data; mn[k] = 1; end
      end else if (mn[k] == 0) p_orph[k] = 1;
      else begin
        mw[k][mn[k]] = in_data;
        mn[k]++;
        if (in_eop && mn[k] < 8) begin p_short[k] = 1; mn[k] = 0; end
        else if (mn[k] == 8) begin
          mn[k] = 0;
          if (!in_eop) begin p_long[k] = 1; m_drop[k] = 1; end
          else begin
            s = {mw[k][0], mw[k][1], mw[k][2], mw[k][3]};
            match = m_lastv[k] && s == m_last[k];
            m_sync[k] = s;
            m_key[k] = {mw[k][4], mw[k][5], mw[k][6], mw[k][7]};
            m_hold[k] = 1;
            m_vld[k] = !(k == 1 && match);
            p_drop[k] = k == 1 && match;
          end
        end
      end
    end
  endtask
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        for (int k = 0; k < 2; k++) step(k);
        m_run = 1;
      end
    end
  end
  task automatic cmp(input int k, input logic rdy, vld, sop, eop, same, se, le, pe, oe, de,
                     input logic [127:0] s, ky, input logic [15:0] cnt);
    bit ev = m_hold[k] && m_vld[k];
    chk($sformatf("rdy%0d", k), rdy, m_run && !m_hold[k]);
    chk($sformatf("valid%0d", k), vld, ev);
    chk($sformatf("sop%0d", k), sop, ev);
    chk($sformatf("eop%0d", k), eop, ev);
    chk($sformatf("same_sync%0d", k), same, ev && m_lastv[k] && m_sync[k] == m_last[k]);
    chk($sformatf("short_err%0d", k), se, p_short[k]);
    chk($sformatf("long_err%0d", k), le, p_long[k]);
    chk($sformatf("sop_err%0d", k), pe, p_sop[k]);
    chk($sformatf("orphan_err%0d", k), oe, p_orph[k]);
    chk($sformatf("drop_same%0d", k), de, p_drop[k]);
    chk($sformatf("hdr_cnt%0d", k), cnt, m_cnt[k]);
    if (ev) begin
      chk($sformatf("sync%0d", k), s, m_sync[k]);
      chk($sformatf("key%0d", k), ky, m_key[k]);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      cmp(0, rdy_a, vld_a, sop_a, eop_a, same_a, short_a, long_a, soperr_a, orph_a, drop_a, sync_a, key_a, cnt_a);
      cmp(1, rdy_b, vld_b, sop_b, eop_b, same_b, short_b, long_b, soperr_b, orph_b, drop_b, sync_b, key_b, 16'(cnt_b));
      if (long_a) n_long++;
      if (soperr_a) n_sop++;
    end
  end
  task automatic put(input logic [31:0] d, input bit s, input bit e);
    int t = 0;
    @(negedge clk);
    in_valid = 0;
    while (!(rdy_a && rdy_b) && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      checks++; failures++;
      $display("FAIL put_timeout rdy_a=%0b rdy_b=%0b required=1", rdy_a, rdy_b);
    end
    in_valid = 1; in_data = d; in_sop = s; in_eop = e;
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask
  // eop on the last of n words; sop on word 0 and on word sop_at
  task automatic send(input logic [255:0] h, input int n, input int sop_at);
    for (int i = 0; i < n; i++)
      put(i < 8 ? h[255-32*i -: 32] : 32'hEE00_0000 + i, i == 0 || i == sop_at, i == n - 1);
    idle();
  endtask
  initial begin
    int l0, s0;
    #12;
    chk("rst_rdy", rdy_a, 0);
    chk("rst_valid", vld_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_sync", sync_a, 0);
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("rel_rdy", rdy_a, 1);
    send(H1, 8, -1);
    chk("h1_valid", vld_a, 1);
    chk("h1_sync", sync_a, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("h1_key", key_a, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("h1_sop", sop_a, 1);
    chk("h1_same", same_a, 0);
    chk("h1_valid_b", vld_b, 1);
    @(negedge clk);
    chk("h1_cnt", cnt_a, 1);
    out_rdy = 0;
    send(H1, 8, -1);
    chk("rep_same", same_a, 1);
    chk("rep_drop_b", drop_b, 1);
    chk("rep_valid_b", vld_b, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", vld_a, 1);
      chk("stall_rdy", rdy_a, 0);
      chk("stall_sync", sync_a, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    end
    out_rdy = 1;
    @(negedge clk);
    chk("rep_cnt_a", cnt_a, 2);
    chk("rep_cnt_b", cnt_b, 1);
    send(H2, 6, -1);
    chk("short_pulse", short_a, 1);
    send(H2, 8, -1);
    chk("h2_sync", sync_a, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);
    @(negedge clk);
    chk("h2_cnt", cnt_a, 3);
    l0 = n_long; s0 = n_sop;
    send(H3, 10, 8);
    @(negedge clk); #1;
    chk("long_pulses", n_long - l0, 1);
    chk("drop_no_soperr", n_sop - s0, 0);
    chk("long_cnt", cnt_a, 3);
    for (int i = 0; i < 3; i++) put(H1[255-32*i -: 32], i == 0, 0);
    send(H3, 8, -1);
    chk("restart_sync", sync_a, 128'hCAFEF00D_55AA55AA_0BADC0DE_76543210);
    chk("restart_key", key_a, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C);
    @(negedge clk); #1;
    chk("restart_soperr", n_sop - s0, 1);
    chk("restart_cnt", cnt_a, 4);
    put(32'h12345678, 0, 1);
    idle();
    chk("orphan_pulse", orph_a, 1);
    for (int i = 0; i < 4; i++) put(H1[255-32*i -: 32], i == 0, 0);
    @(negedge clk);
    in_valid = 1; in_data = 32'h8899AABB; in_sop = 0; in_eop = 0;
    #2 rst_n = 0; in_valid = 0;
    @(negedge clk);
    chk("mid_rst_valid", vld_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_rdy", rdy_a, 0);
    #2 rst_n = 1;
    send(H1, 8, -1);
    chk("post_rst_valid", vld_a, 1);
    chk("post_rst_same", same_a, 0);
    chk("post_rst_valid_b", vld_b, 1);
    @(negedge clk);
    chk("post_rst_cnt", cnt_a, 1);
    send(H2, 8, -1);
    send(H3, 8, -1);
    send(H2, 8, -1);
    send(H3, 8, -1);
    @(negedge clk);
    chk("wrap_cnt_a", cnt_a, 5);
    chk("wrap_cnt_b", cnt_b, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
